// File: rtl/vec_player.sv
// Vector player: streams stored stimulus words to a DUT, compares each response
// against the stored expected word, and folds every response into a MISR signature.
module vec_player #(
    parameter int IN_W   = 50,
    parameter int OUT_W  = 22,
    parameter int DEPTH  = 10,
    parameter int SETTLE = 1,
    parameter logic [OUT_W-1:0] POLY = 22'h200003,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [IN_W-1:0]   load_stim,
    input  logic [OUT_W-1:0]  load_exp,
    input  logic              start,
    input  logic [AW:0]       num_vec,
    output logic [IN_W-1:0]   dut_in,
    input  logic [OUT_W-1:0]  dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [AW:0]       fail_cnt,
    output logic [AW-1:0]     first_fail_idx,
    output logic [OUT_W-1:0]  signature
);
    localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    typedef enum logic [2:0] {IDLE, APPLY, SETTLE_S, CAPTURE, DONE} state_t;

    state_t state, state_n;

    logic [IN_W-1:0]  stim_mem [DEPTH];
    logic [OUT_W-1:0] exp_mem  [DEPTH];

    logic [AW-1:0] idx;
    logic [AW-1:0] idx_nxt;
    logic [AW:0]   n_reg;
    logic [AW:0]   n_in;
    logic [SW-1:0] scnt;
    logic          wr_ok;
    logic          last;
    logic          miss;

    assign wr_ok   = load_en && (state == IDLE) && (32'(load_addr) < DEPTH);
    assign n_in    = (32'(num_vec) > DEPTH) ? (AW+1)'(DEPTH) : num_vec;
    assign idx_nxt = idx + AW'(1);
    assign last    = ({1'b0, idx} == n_reg - (AW+1)'(1));
    assign miss    = (dut_out != exp_mem[idx]);
    assign busy    = (state == APPLY) || (state == SETTLE_S) || (state == CAPTURE);
    assign done    = (state == DONE);

    // Memory survives reset; rst only blocks a write issued in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            stim_mem[load_addr] <= load_stim;
            exp_mem[load_addr]  <= load_exp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (start) state_n = (n_in == '0) ? DONE : APPLY;
            APPLY:    state_n = (SETTLE == 0) ? CAPTURE : SETTLE_S;
            SETTLE_S: if (32'(scnt) == SETTLE - 1) state_n = CAPTURE;
            CAPTURE:  state_n = last ? DONE : APPLY;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx            <= '0;
            n_reg          <= '0;
            scnt           <= '0;
            dut_in         <= '0;
            pass           <= 1'b0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            signature      <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    n_reg          <= n_in;
                    idx            <= '0;
                    pass           <= 1'b0;
                    fail_cnt       <= '0;
                    first_fail_idx <= '0;
                    signature      <= '0;
                    // A same-cycle write to entry 0 must be visible to this run.
                    if (n_in != '0)
                        dut_in <= (wr_ok && load_addr == '0) ? load_stim : stim_mem[0];
                end
                APPLY:    scnt <= '0;
                SETTLE_S: scnt <= scnt + SW'(1);
                CAPTURE: begin
                    signature <= (signature << 1) ^ (signature[OUT_W-1] ? POLY : '0) ^ dut_out;
                    if (miss) begin
                        if (fail_cnt != '1) fail_cnt <= fail_cnt + (AW+1)'(1);
                        if (fail_cnt == '0) first_fail_idx <= idx;
                    end
                    if (!last) begin
                        idx    <= idx_nxt;
                        dut_in <= stim_mem[idx_nxt];
                    end
                end
                DONE:     pass <= (fail_cnt == '0);
                default:  ;
            endcase
        end
    end
endmodule

// File: tb/tb_vec_player.sv
// Randomized bench for vec_player: loopback or forced DUT response, results
// checked against an array-based model of a whole run.
module tb_vec_player;
    localparam int IN_W   = 50;
    localparam int OUT_W  = 22;
    localparam int DEPTH  = 10;
    localparam int SETTLE = 1;
    localparam logic [OUT_W-1:0] POLY = 22'h200003;
    localparam int AW = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst;
    logic              load_en;
    logic [AW-1:0]     load_addr;
    logic [IN_W-1:0]   load_stim;
    logic [OUT_W-1:0]  load_exp;
    logic              start;
    logic [AW:0]       num_vec;
    logic [IN_W-1:0]   dut_in;
    logic [OUT_W-1:0]  dut_out;
    logic              busy, done, pass;
    logic [AW:0]       fail_cnt;
    logic [AW-1:0]     first_fail_idx;
    logic [OUT_W-1:0]  signature;

    logic resp_one = 1'b0;
    assign dut_out = resp_one ? OUT_W'(1) : dut_in[OUT_W-1:0];

    vec_player #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .SETTLE(SETTLE), .POLY(POLY)) u_dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_stim(load_stim), .load_exp(load_exp), .start(start), .num_vec(num_vec),
        .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
        .fail_cnt(fail_cnt), .first_fail_idx(first_fail_idx), .signature(signature)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [IN_W-1:0]  m_stim [DEPTH];
    logic [OUT_W-1:0] m_exp  [DEPTH];
    logic             e_pass;
    int               e_fc, e_ffi;
    logic [OUT_W-1:0] e_sig;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IN_W-1:0] rnd_stim();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[IN_W-1:0];
    endfunction

    // Whole-run outcome from the stored vectors and the loopback/forced response.
    function automatic void model(input int nv);
        int n;
        logic [OUT_W-1:0] r;
        n = (nv > DEPTH) ? DEPTH : nv;
        e_fc = 0; e_ffi = 0; e_sig = '0;
        for (int i = 0; i < n; i++) begin
            r = resp_one ? OUT_W'(1) : m_stim[i][OUT_W-1:0];
            if (r != m_exp[i]) begin
                if (e_fc == 0) e_ffi = i;
                e_fc++;
            end
            e_sig = (e_sig << 1) ^ (e_sig[OUT_W-1] ? POLY : '0) ^ r;
        end
        if (e_fc > 2**(AW+1) - 1) e_fc = 2**(AW+1) - 1;
        e_pass = (e_fc == 0);
    endfunction

    task automatic load(input int a, input logic [IN_W-1:0] s, input logic [OUT_W-1:0] e);
        @(posedge clk); #1;
        load_en = 1'b1; load_addr = AW'(a); load_stim = s; load_exp = e;
        if (a < DEPTH) begin m_stim[a] = s; m_exp[a] = e; end
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic load_all();
        logic [IN_W-1:0] s;
        for (int i = 0; i < DEPTH; i++) begin
            s = rnd_stim();
            load(i, s, s[OUT_W-1:0]);
        end
    endtask

    // poke: mid-run start and write (both ignored); co_load: write entry 0 with start.
    task automatic run(input int nv, input bit poke, input bit co_load);
        int cyc, n, vlen;
        logic [IN_W-1:0] s;
        n = (nv > DEPTH) ? DEPTH : nv;
        vlen = SETTLE + 2;
        @(posedge clk); #1;
        start = 1'b1; num_vec = (AW+1)'(nv);
        if (co_load) begin
            s = rnd_stim();
            load_en = 1'b1; load_addr = '0; load_stim = s; load_exp = s[OUT_W-1:0];
            m_stim[0] = s; m_exp[0] = s[OUT_W-1:0];
        end
        model(nv);
        @(posedge clk); #1;
        start = 1'b0; load_en = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            chk("busy_in_run", 64'(busy), 64'(1));
            chk("dut_in", 64'(dut_in), 64'(m_stim[(cyc - 1) / vlen]));
            if (poke && cyc == 4) begin
                start = 1'b1; num_vec = 1;
                load_en = 1'b1; load_addr = '0; load_stim = ~m_stim[0]; load_exp = ~m_exp[0];
            end else begin
                start = 1'b0; load_en = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; load_en = 1'b0;
        chk("run_len", 64'(cyc), 64'((n == 0) ? 1 : n * vlen + 1));
        chk("busy_at_done", 64'(busy), 64'(0));
        @(posedge clk); #1;
        chk("done_pulse", 64'(done), 64'(0));
        chk("pass", 64'(pass), 64'(e_pass));
        chk("fail_cnt", 64'(fail_cnt), 64'(e_fc));
        chk("first_fail_idx", 64'(first_fail_idx), 64'(e_ffi));
        chk("signature", 64'(signature), 64'(e_sig));
    endtask

    initial begin
        logic [IN_W-1:0] s;
        rst = 1'b1; load_en = 1'b0; load_addr = '0; load_stim = '0; load_exp = '0;
        start = 1'b0; num_vec = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_pass", 64'(pass), 64'(0));
        chk("rst_fail_cnt", 64'(fail_cnt), 64'(0));
        chk("rst_ffi", 64'(first_fail_idx), 64'(0));
        chk("rst_sig", 64'(signature), 64'(0));
        chk("rst_dut_in", 64'(dut_in), 64'(0));
        rst = 1'b0;

        load_all();
        run(10, 0, 0);
        chk("loop_pass", 64'(pass), 64'(1));
        chk("loop_fc", 64'(fail_cnt), 64'(0));

        load(3, m_stim[3], m_exp[3] ^ 22'h1);
        load(7, m_stim[7], m_exp[7] ^ 22'h100);
        run(10, 0, 0);
        chk("corr_pass", 64'(pass), 64'(0));
        chk("corr_fc", 64'(fail_cnt), 64'(2));
        chk("corr_ffi", 64'(first_fail_idx), 64'(3));

        run(0, 0, 0);
        chk("zero_sig", 64'(signature), 64'(0));
        run(15, 0, 0);

        resp_one = 1'b1;
        run(2, 0, 0);
        chk("misr_2", 64'(signature), 64'(22'h000003));
        run(1, 0, 0);
        chk("misr_1", 64'(signature), 64'(22'h000001));
        resp_one = 1'b0;

        // Abort during SETTLE of vector 4, then rerun on retained memory.
        load(3, m_stim[3], m_stim[3][OUT_W-1:0]);
        load(7, m_stim[7], m_stim[7][OUT_W-1:0]);
        @(posedge clk); #1;
        start = 1'b1; num_vec = 10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4 * (SETTLE + 2) + 1) @(posedge clk);
        #1;
        chk("pre_abort_dut_in", 64'(dut_in), 64'(m_stim[4]));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_dut_in", 64'(dut_in), 64'(0));
        for (int i = 0; i < 5; i++) begin
            chk("abort_no_done", 64'(done), 64'(0));
            @(posedge clk); #1;
        end
        run(10, 0, 0);
        chk("rerun_pass", 64'(pass), 64'(1));

        // Out-of-range writes must leave memory untouched.
        for (int a = DEPTH; a < 2**AW; a++) load(a, rnd_stim(), OUT_W'($urandom()));
        run(10, 0, 0);

        run(10, 1, 0);
        run(10, 0, 0);
        run(3, 0, 1);

        // rst wins over start in the same cycle.
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1; num_vec = 5;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk("rst_prio_busy", 64'(busy), 64'(0));
        chk("rst_prio_done", 64'(done), 64'(0));

        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 3; j++) begin
                int a;
                a = $urandom_range(DEPTH - 1);
                s = rnd_stim();
                load(a, s, ($urandom_range(2) == 0) ? OUT_W'($urandom()) : s[OUT_W-1:0]);
            end
            run($urandom_range(15), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
